// File: rtl/backend_types.sv
// Shared back-end types: reservation-station entry layout, issue depth and
// branch-tag sizing, plus small helpers for branch-mask manipulation.
package backend_types;

  localparam int INT_ISSUE_DEPTH = 8;
  localparam int BR_TAG_W        = 2;
  localparam int BR_MASK_W       = 1 << BR_TAG_W;

  typedef struct packed {
    logic [BR_MASK_W-1:0] branch_mask;  // one bit per unresolved branch this op depends on
    logic [6:0]           opcode;
    logic [5:0]           prd;
    logic [5:0]           prs1;
    logic [5:0]           prs2;
    logic [31:0]          imm;
  } res_entry_t;

  function automatic res_entry_t clear_branch(input res_entry_t e,
                                              input logic [BR_TAG_W-1:0] tag);
    res_entry_t r;
    r = e;
    r.branch_mask[tag] = 1'b0;
    return r;
  endfunction

  function automatic logic depends_on(input res_entry_t e,
                                      input logic [BR_TAG_W-1:0] tag);
    return e.branch_mask[tag];
  endfunction

endpackage

// File: rtl/issue_select_age_matrix.sv
// Age matrix for the issue queue: tracks relative allocation order of entries
// and picks the oldest requesting entry as a one-hot grant plus its index.
module age_matrix #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid_i,
  input  logic [ADDR_WIDTH-1:0] alloc_idx_i,
  input  logic [DEPTH-1:0]      req_i,
  output logic [DEPTH-1:0]      grant_oh_o,
  output logic [ADDR_WIDTH-1:0] grant_idx_o
);

  // older_q[i][j] = 1 means entry i was allocated before entry j.
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  logic [DEPTH-1:0]            cand;
  logic [DEPTH-1:0]            pick;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    older_d = older_q;
    if (alloc_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (ADDR_WIDTH'(i) == alloc_idx_i)      older_d[i][j] = 1'b0;
          else if (ADDR_WIDTH'(j) == alloc_idx_i) older_d[i][j] = 1'b1;
        end
      end
    end
  end

  // NOTE: this flop array is reset (unlike a data RAM) because a clean
  // all-zero matrix is what makes the first allocations order correctly;
  // state registers use non-blocking '<='.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) older_q <= '0;
    else     older_q <= older_d;
  end

  // An entry wins when no other requester is older than it.
  always_comb begin
    cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        blocked = blocked | (req_i[j] & older_q[j][i]);
      end
      cand[i] = req_i[i] & ~blocked;
    end
  end

  // Lowest-index tie break keeps the grant one-hot even for entries whose
  // relative age was never recorded (e.g. straight out of reset).
  always_comb begin
    pick        = (|cand) ? cand : req_i;
    grant_oh_o  = pick & (~pick + DEPTH'(1));
    grant_idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_oh_o[i]) grant_idx_o = ADDR_WIDTH'(i);
    end
  end

endmodule

// File: rtl/issue_select.sv
// Oldest-first issue selection from an integer reservation station into a
// single-entry issue register, with branch kill/clean applied in flight.
module issue_select
  import backend_types::*;
#(
  parameter int DEPTH      = INT_ISSUE_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_idx,
  input  logic [DEPTH-1:0]      req,
  input  res_entry_t            rdata,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  brb_broadcast,
  input  logic                  brb_clean,
  input  logic                  brb_kill,
  input  logic [BR_TAG_W-1:0]   brb_tag,
  input  logic                  fu_ready,
  output logic                  issue_valid,
  output res_entry_t            issue_data
);

  logic [DEPTH-1:0]      grant_oh;
  logic [ADDR_WIDTH-1:0] grant_idx;
  logic                  kill_evt, clean_evt;
  logic                  issue_valid_q, issue_valid_d;
  res_entry_t            issue_data_q, issue_data_d;
  res_entry_t            rd_clean, held_clean;

  age_matrix #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_age (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid_i(alloc_valid),
    .alloc_idx_i  (alloc_idx),
    .req_i        (req),
    .grant_oh_o   (grant_oh),
    .grant_idx_o  (grant_idx)
  );

  // A kill outranks a clean if both are flagged on the same broadcast.
  assign kill_evt  = brb_broadcast & brb_kill;
  assign clean_evt = brb_broadcast & brb_clean & ~brb_kill;

  assign ren   = ~rst & (|grant_oh) & (~issue_valid_q | fu_ready);
  assign raddr = rst ? '0 : grant_idx;

  always_comb begin
    rd_clean      = clean_evt ? clear_branch(rdata, brb_tag) : rdata;
    held_clean    = clean_evt ? clear_branch(issue_data_q, brb_tag) : issue_data_q;
    issue_data_d  = held_clean;
    issue_valid_d = issue_valid_q;
    if (ren) begin
      // A squashed capture still dequeues the station entry, it just never goes live.
      issue_data_d  = rd_clean;
      issue_valid_d = ~(kill_evt & depends_on(rdata, brb_tag));
    end else if (issue_valid_q & kill_evt & depends_on(issue_data_q, brb_tag)) begin
      issue_valid_d = 1'b0;
    end else if (issue_valid_q & fu_ready) begin
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_q <= 1'b0;
      issue_data_q  <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_data_q  <= issue_data_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_data  = issue_data_q;

endmodule
